fab_uart_rx: RTL and testbench



---
 rtl/fab_uart_pkg.sv | 20 ++
 rtl/fab_uart_rx_if.sv | 25 ++
 rtl/fab_uart_rx_fifo.sv | 56 +++++
 rtl/fab_uart_rx.sv | 173 +++++++++++++++++
 tb/tb_fab_uart_rx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fab_uart_pkg.sv
// Shared constants and state encoding for the fabric-side UART receiver.
// Oversampling ratio, frame geometry and the receiver FSM states live here.
package fab_uart_pkg;

   localparam int OVERSAMPLE   = 16;
   localparam int DATA_BITS    = 8;
   localparam int START_SAMPLE = 7;

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/fab_uart_rx_if.sv
// Fabric-side bundle of the UART receiver: serial line in, FIFO read port and
// status/error flags out. The receiver is the slave; fabric logic is the master.
interface fab_uart_rx_if;

   logic       RX;
   logic       RD_EN;
   logic [7:0] RD_DATA;
   logic       EMPTY;
   logic       FULL;
   logic       INT;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       ERR_CLR;

   modport slave (
      input  RX, RD_EN, ERR_CLR,
      output RD_DATA, EMPTY, FULL, INT, FRAME_ERR, OVERRUN
   );

   modport master (
      output RX, RD_EN, ERR_CLR,
      input  RD_DATA, EMPTY, FULL, INT, FRAME_ERR, OVERRUN
   );

endinterface

// File: rtl/fab_uart_rx_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on rd_data while
// not empty; a push into a full FIFO is taken only when a pop frees a slot.
module fab_uart_rx_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = rd_en && !empty;
   assign do_push = wr_en && (!full || do_pop);

   // Head is forced to zero when empty so the output has a defined reset value.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and count need one,
   // and leaving the array unreset lets it map onto plain RAM/LUT storage.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fab_uart_rx.sv
// 8N1 UART receiver (LSB first) with 16x oversampling, show-ahead byte FIFO,
// framing-error pulse, sticky overrun flag and a level interrupt.
module fab_uart_rx
   import fab_uart_pkg::*;
#(
   parameter int BAUD_DIV   = 27,
   parameter int FIFO_DEPTH = 16
) (
   input  logic         CLK,
   input  logic         RESET_N,
   fab_uart_rx_if.slave bus
);

   localparam int PW = $clog2(BAUD_DIV);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [PW-1:0]     PRESC_MAX  = PW'(BAUD_DIV - 1);
   localparam logic [TICK_W-1:0] START_TICK = TICK_W'(START_SAMPLE);
   localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_BITS - 1);

   rx_state_t            state;
   rx_state_t            state_next;
   logic                 rx_meta;
   logic                 rx_sync;
   logic [PW-1:0]        presc;
   logic                 tick;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 tick_clr;
   logic                 bit_clr;
   logic                 shift_en;
   logic                 push_req;
   logic                 frame_err_set;
   logic                 overrun_set;
   logic                 frame_err;
   logic                 overrun;
   logic [7:0]           fifo_data;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [CW-1:0]        fifo_count;

   // NOTE: sequential state is always assigned with <= so every flop samples
   // pre-edge values; blocking here would make the synchroniser collapse.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= bus.RX;
         rx_sync <= rx_meta;
      end
   end

   assign tick = (presc == PRESC_MAX);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next    = state;
      tick_clr      = 1'b0;
      bit_clr       = 1'b0;
      shift_en      = 1'b0;
      push_req      = 1'b0;
      frame_err_set = 1'b0;
      unique case (state)
         IDLE: begin
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
            if (!rx_sync) state_next = START;
         end
         START: begin
            if (tick && tick_cnt == START_TICK) begin
               if (!rx_sync) begin
                  state_next = DATA;
                  tick_clr   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (tick && tick_cnt == LAST_TICK) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) state_next = STOP;
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit keeps the receiver ready for a start bit
            // that follows immediately.
            if (tick && tick_cnt == LAST_TICK) begin
               if (rx_sync) begin
                  push_req   = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_err_set = 1'b1;
                  state_next    = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_sync) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         presc     <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (state == IDLE || tick) presc <= '0;
         else                       presc <= presc + PW'(1);

         if (tick_clr)  tick_cnt <= '0;
         else if (tick) tick_cnt <= tick_cnt + TICK_W'(1);

         if (bit_clr)       bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + BIT_W'(1);

         if (shift_en) shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
      end
   end

   // A good byte is lost only if the FIFO is full and nobody pops this cycle.
   assign overrun_set = push_req && (fifo_count == CW'(FIFO_DEPTH)) && !bus.RD_EN;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_err_set;
         if (overrun_set)      overrun <= 1'b1;
         else if (bus.ERR_CLR) overrun <= 1'b0;
      end
   end

   fab_uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .wr_en   (push_req),
      .wr_data (shift_reg),
      .rd_en   (bus.RD_EN),
      .rd_data (fifo_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign bus.RD_DATA   = fifo_data;
   assign bus.EMPTY     = fifo_empty;
   assign bus.FULL      = fifo_full;
   assign bus.FRAME_ERR = frame_err;
   assign bus.OVERRUN   = overrun;
   assign bus.INT       = !fifo_empty || overrun;

endmodule

// File: tb/tb_fab_uart_rx.sv
// Bench for fab_uart_rx: directed frames plus random traffic, checked against
// a queue-based model of the receive FIFO and the overrun flag.
module tb_fab_uart_rx;

   localparam int BAUD_DIV   = 4;
   localparam int FIFO_DEPTH = 16;
   localparam int BIT_CYC    = 16 * BAUD_DIV;

   logic CLK     = 1'b0;
   logic RESET_N = 1'b0;

   int vectors     = 0;
   int miscompares = 0;
   int fe_cnt      = 0;

   logic [7:0] model_q[$];
   logic       model_ovr = 1'b0;

   fab_uart_rx_if bus();

   fab_uart_rx #(
      .BAUD_DIV   (BAUD_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (bus.FRAME_ERR === 1'b1) fe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drive_bit(input logic v, input int n_bits);
      bus.RX = v;
      idle(n_bits * BIT_CYC);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
      drive_bit(1'b0, 1);
      for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
      drive_bit(stop, stop_len);
      bus.RX = 1'b1;
   endtask

   // Good frame arrives: stored if there is room, otherwise overrun.
   task automatic model_rx(input logic [7:0] b);
      if (model_q.size() == FIFO_DEPTH) model_ovr = 1'b1;
      else model_q.push_back(b);
   endtask

   task automatic check_state(input string tag);
      @(negedge CLK);
      check({tag, ".empty"},   32'(bus.EMPTY),   32'(model_q.size() == 0));
      check({tag, ".full"},    32'(bus.FULL),    32'(model_q.size() == FIFO_DEPTH));
      check({tag, ".overrun"}, 32'(bus.OVERRUN), 32'(model_ovr));
      check({tag, ".int"},     32'(bus.INT),     32'(model_q.size() != 0 || model_ovr));
      if (model_q.size() != 0) check({tag, ".data"}, 32'(bus.RD_DATA), 32'(model_q[0]));
      @(posedge CLK);
      #1;
   endtask

   task automatic pop_item(input string tag);
      bus.RD_EN = 1'b1;
      idle(1);
      bus.RD_EN = 1'b0;
      if (model_q.size() != 0) void'(model_q.pop_front());
      check_state(tag);
   endtask

   task automatic err_clr(input string tag);
      bus.ERR_CLR = 1'b1;
      idle(1);
      bus.ERR_CLR = 1'b0;
      model_ovr = 1'b0;
      check_state(tag);
   endtask

   initial begin
      int lat;
      int fe0;
      logic [7:0] rb;

      bus.RX      = 1'b1;
      bus.RD_EN   = 1'b0;
      bus.ERR_CLR = 1'b0;
      idle(5);

      // Reset values, then a long idle line.
      check("rst.rd_data", 32'(bus.RD_DATA), 32'h0);
      check("rst.frame_err", 32'(bus.FRAME_ERR), 32'h0);
      check_state("rst");
      RESET_N = 1'b1;
      idle(1000);
      check_state("idle");
      check("idle.fe_pulses", 32'(fe_cnt), 32'd0);

      // 0xA5 with arrival time measured from the start edge.
      lat = -1;
      fork
         send_frame(8'hA5, 1'b1, 1);
         begin
            for (int i = 0; i < 800; i++) begin
               @(negedge CLK);
               if (!bus.EMPTY) begin
                  lat = i;
                  break;
               end
            end
         end
      join
      model_rx(8'hA5);
      check("a5.latency_window", 32'(lat >= 600 && lat <= 620), 32'd1);
      check_state("a5");
      pop_item("a5.pop");
      pop_item("empty.pop_ignored");

      // Short low glitch is rejected silently.
      fe0 = fe_cnt;
      bus.RX = 1'b0;
      idle(20);
      bus.RX = 1'b1;
      idle(200);
      check_state("glitch");
      check("glitch.fe_pulses", 32'(fe_cnt - fe0), 32'd0);

      // Bad stop bit held low for three bit times, then a good frame.
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 3);
      idle(BIT_CYC);
      check("ferr.fe_pulses", 32'(fe_cnt - fe0), 32'd1);
      check_state("ferr");
      send_frame(8'h55, 1'b1, 1);
      model_rx(8'h55);
      check_state("after_ferr");
      pop_item("after_ferr.pop");

      // 17 bytes with no reads: fill, then overrun on the last.
      for (int b = 0; b <= 16; b++) begin
         send_frame(8'(b), 1'b1, 1);
         model_rx(8'(b));
         if (b >= 15) check_state("fill");
      end
      for (int i = 0; i < FIFO_DEPTH; i++) pop_item("drain");
      check_state("drained");
      err_clr("ovr_clr");

      // Reset in the middle of 0x81 with a byte already buffered.
      send_frame(8'h11, 1'b1, 1);
      model_rx(8'h11);
      check_state("pre_rst");
      drive_bit(1'b0, 1);
      drive_bit(1'b1, 1);
      drive_bit(1'b0, 1);
      drive_bit(1'b0, 1);
      drive_bit(1'b0, 1);
      RESET_N = 1'b0;
      bus.RX  = 1'b1;
      model_q.delete();
      model_ovr = 1'b0;
      idle(3);
      check("midrst.rd_data", 32'(bus.RD_DATA), 32'h0);
      check("midrst.frame_err", 32'(bus.FRAME_ERR), 32'h0);
      check_state("midrst");
      RESET_N = 1'b1;
      idle(BIT_CYC);
      check_state("post_rst");
      send_frame(8'h7E, 1'b1, 1);
      model_rx(8'h7E);
      check_state("rx_7e");
      pop_item("rx_7e.pop");

      // Random bytes, gaps, reads and error clears.
      for (int n = 0; n < 24; n++) begin
         rb = 8'($urandom_range(0, 255));
         idle($urandom_range(0, 40));
         send_frame(rb, 1'b1, 1);
         model_rx(rb);
         check_state("rand.rx");
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            if (model_q.size() != 0) pop_item("rand.pop");
         end
         if ($urandom_range(0, 7) == 0) err_clr("rand.clr");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
